// File: rtl/sample_frame_reader.sv
// Snapshots the 16-tap microphone window every HOP sampling strobes and streams it
// oldest-first over a valid/ready handshake, entirely in the clk_25 domain.
module sample_frame_reader #(
   parameter int WIDTH = 18,
   parameter int HOP = 16
) (
   input  logic             clk_25,
   input  logic             reset,
   input  logic             clk_sampling,
   input  logic [WIDTH-1:0] s0,
   input  logic [WIDTH-1:0] s1,
   input  logic [WIDTH-1:0] s2,
   input  logic [WIDTH-1:0] s3,
   input  logic [WIDTH-1:0] s4,
   input  logic [WIDTH-1:0] s5,
   input  logic [WIDTH-1:0] s6,
   input  logic [WIDTH-1:0] s7,
   input  logic [WIDTH-1:0] s8,
   input  logic [WIDTH-1:0] s9,
   input  logic [WIDTH-1:0] s10,
   input  logic [WIDTH-1:0] s11,
   input  logic [WIDTH-1:0] s12,
   input  logic [WIDTH-1:0] s13,
   input  logic [WIDTH-1:0] s14,
   input  logic [WIDTH-1:0] s15,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_index,
   output logic             out_last,
   output logic             busy,
   output logic             overrun,
   input  logic             overrun_clr,
   output logic [7:0]       frame_count
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      STREAM
   } state_t;

   localparam logic [4:0] HOP_LAST = 5'(HOP - 1);

   state_t state;
   state_t next_state;

   logic             sync1;
   logic             sync2;
   logic             sync3;
   logic             tick;
   logic [4:0]       hop_count;
   logic             frame_due;
   logic             capture_frame;
   logic             beat_xfer;
   logic [3:0]       next_index;
   logic [WIDTH-1:0] taps [16];
   logic [WIDTH-1:0] buffer [16];

   // taps/buffer are ordered by stream position: entry 0 is the oldest sample
   assign taps[0]  = s15;
   assign taps[1]  = s14;
   assign taps[2]  = s13;
   assign taps[3]  = s12;
   assign taps[4]  = s11;
   assign taps[5]  = s10;
   assign taps[6]  = s9;
   assign taps[7]  = s8;
   assign taps[8]  = s7;
   assign taps[9]  = s6;
   assign taps[10] = s5;
   assign taps[11] = s4;
   assign taps[12] = s3;
   assign taps[13] = s2;
   assign taps[14] = s1;
   assign taps[15] = s0;

   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= clk_sampling;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign tick = sync2 && !sync3;
   assign frame_due = tick && (hop_count == HOP_LAST);

   // The hop counter free-runs on ticks so frame spacing is independent of drops
   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         hop_count <= '0;
      end else if (tick) begin
         if (hop_count == HOP_LAST) begin
            hop_count <= '0;
         end else begin
            hop_count <= hop_count + 5'd1;
         end
      end
   end

   assign out_valid  = (state == STREAM);
   assign busy       = (state != IDLE);
   assign out_last   = out_valid && (out_index == 4'd15);
   assign beat_xfer  = out_valid && out_ready;
   assign next_index = out_index + 4'd1;

   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      capture_frame = 1'b0;
      case (state)
         IDLE: begin
            if (frame_due) begin
               next_state = CAPTURE;
               capture_frame = 1'b1;
            end
         end
         CAPTURE: begin
            next_state = STREAM;
         end
         STREAM: begin
            if (beat_xfer && (out_index == 4'd15)) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // The window is copied on the frame_due cycle itself, while s0..s15 are known settled
   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            buffer[i] <= '0;
         end
      end else if (capture_frame) begin
         for (int i = 0; i < 16; i++) begin
            buffer[i] <= taps[i];
         end
      end
   end

   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_index <= '0;
      end else if (state == CAPTURE) begin
         out_data  <= buffer[0];
         out_index <= 4'd0;
      end else if (beat_xfer && (out_index != 4'd15)) begin
         out_data  <= buffer[next_index];
         out_index <= next_index;
      end
   end

   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         frame_count <= '0;
      end else if (beat_xfer && (out_index == 4'd15)) begin
         frame_count <= frame_count + 8'd1;
      end
   end

   // A dropped frame outranks a simultaneous clear so no drop goes unreported
   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (frame_due && busy) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sample_frame_reader.sv
// Scoreboard bench: three readers (HOP 16, 4, 1) share one sample window and strobe,
// each checked against a frame-level model of snapshots, drops and counts.
module tb_sample_frame_reader;

   localparam int WIDTH = 18;
   localparam int NDUT = 3;
   localparam int HOPS[NDUT] = '{16, 4, 1};

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [3:0]       index;
      logic             last;
   } beat_t;

   logic             clk_25 = 1'b0;
   logic             reset = 1'b1;
   logic             clk_sampling = 1'b0;
   logic [WIDTH-1:0] win [16];
   logic [WIDTH-1:0] out_data [NDUT];
   logic             out_valid [NDUT];
   logic             out_ready [NDUT];
   logic [3:0]       out_index [NDUT];
   logic             out_last [NDUT];
   logic             busy [NDUT];
   logic             overrun [NDUT];
   logic             overrun_clr [NDUT];
   logic [7:0]       frame_count [NDUT];

   beat_t exp_q [NDUT][$];
   int    ticks = 0;
   int    exp_frames [NDUT];
   bit    exp_overrun [NDUT];
   bit    dropped [NDUT];
   int    ready_mode [NDUT];
   bit    ready_force [NDUT];
   int    stall [NDUT];
   int    pat [NDUT];
   bit    shift_window = 1'b0;
   int    checks = 0;
   int    passes = 0;

   always #20 clk_25 = ~clk_25;

   genvar g;
   generate
      for (g = 0; g < NDUT; g++) begin : g_dut
         sample_frame_reader #(
            .WIDTH(WIDTH),
            .HOP(HOPS[g])
         ) dut (
            .clk_25(clk_25),
            .reset(reset),
            .clk_sampling(clk_sampling),
            .s0(win[0]),
            .s1(win[1]),
            .s2(win[2]),
            .s3(win[3]),
            .s4(win[4]),
            .s5(win[5]),
            .s6(win[6]),
            .s7(win[7]),
            .s8(win[8]),
            .s9(win[9]),
            .s10(win[10]),
            .s11(win[11]),
            .s12(win[12]),
            .s13(win[13]),
            .s14(win[14]),
            .s15(win[15]),
            .out_data(out_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_index(out_index[g]),
            .out_last(out_last[g]),
            .busy(busy[g]),
            .overrun(overrun[g]),
            .overrun_clr(overrun_clr[g]),
            .frame_count(frame_count[g])
         );
      end
   endgenerate

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk_25);
      #1;
   endtask

   // Frame-level model: every HOP-th strobe snapshots the window unless a frame is still owed
   task automatic modelEdge();
      ticks++;
      for (int d = 0; d < NDUT; d++) begin
         dropped[d] = 1'b0;
         if (ticks % HOPS[d] == 0) begin
            if (exp_q[d].size() != 0) begin
               exp_overrun[d] = 1'b1;
               dropped[d] = 1'b1;
            end else begin
               for (int i = 0; i < 16; i++) begin
                  exp_q[d].push_back('{data: win[15 - i], index: 4'(i), last: (i == 15)});
               end
               exp_frames[d]++;
            end
         end
      end
   endtask

   task automatic applyStimulus(input int n, input bit clr_tick, input int high_cycles, input int low_cycles);
      for (int k = 0; k < n; k++) begin
         waitCycles(low_cycles);
         if (shift_window) begin
            for (int j = 15; j > 0; j--) begin
               win[j] = win[j - 1];
            end
            win[0] = WIDTH'($urandom);
         end
         clk_sampling = 1'b1;
         modelEdge();
         if (clr_tick) begin
            waitCycles(2);
            overrun_clr[1] = 1'b1;
            if (!dropped[1]) begin
               exp_overrun[1] = 1'b0;
            end
            waitCycles(1);
            overrun_clr[1] = 1'b0;
            waitCycles(high_cycles - 3);
         end else begin
            waitCycles(high_cycles);
         end
         clk_sampling = 1'b0;
      end
   endtask

   task automatic checkStatus(input string tag);
      for (int d = 0; d < NDUT; d++) begin
         checkOutput($sformatf("%s dut%0d frame_count", tag, d), 32'(frame_count[d]), 32'(exp_frames[d] % 256));
         checkOutput($sformatf("%s dut%0d overrun", tag, d), 32'(overrun[d]), 32'(exp_overrun[d]));
         checkOutput($sformatf("%s dut%0d out_valid", tag, d), 32'(out_valid[d]), 32'(exp_q[d].size() != 0));
         checkOutput($sformatf("%s dut%0d busy", tag, d), 32'(busy[d]), 32'(exp_q[d].size() != 0));
      end
   endtask

   // Monitor: each accepted beat must be the next one the model owes that reader
   always @(negedge clk_25) begin
      beat_t e;
      if (reset !== 1'b1) begin
         for (int d = 0; d < NDUT; d++) begin
            if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
               if (exp_q[d].size() == 0) begin
                  checkOutput($sformatf("dut%0d unexpected beat idx %0d", d, out_index[d]), 32'd1, 32'd0);
               end else begin
                  e = exp_q[d].pop_front();
                  checkOutput($sformatf("dut%0d beat data", d), 32'(out_data[d]), 32'(e.data));
                  checkOutput($sformatf("dut%0d beat index", d), 32'(out_index[d]), 32'(e.index));
                  checkOutput($sformatf("dut%0d beat last", d), 32'(out_last[d]), 32'(e.last));
               end
            end
         end
      end
   end

   // Ready driver: forced level, bounded-stall random, or the 1,0,0 pattern
   always @(posedge clk_25) begin
      #1;
      for (int d = 0; d < NDUT; d++) begin
         case (ready_mode[d])
            1: begin
               if (stall[d] >= 3 || $urandom_range(0, 3) != 0) begin
                  out_ready[d] = 1'b1;
                  stall[d] = 0;
               end else begin
                  out_ready[d] = 1'b0;
                  stall[d]++;
               end
            end
            2: begin
               out_ready[d] = (pat[d] == 0);
               pat[d] = (pat[d] == 2) ? 0 : pat[d] + 1;
            end
            default: out_ready[d] = ready_force[d];
         endcase
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;
      for (int j = 0; j < 16; j++) begin
         win[j] = WIDTH'(32'h100 + j);
      end
      for (int d = 0; d < NDUT; d++) begin
         overrun_clr[d] = 1'b0;
         ready_mode[d] = 0;
         ready_force[d] = 1'b1;
         stall[d] = 0;
         pat[d] = 0;
         exp_frames[d] = 0;
         exp_overrun[d] = 1'b0;
         out_ready[d] = 1'b0;
      end
      reset = 1'b1;
      waitCycles(4);
      reset = 1'b0;
      waitCycles(2);
      checkStatus("reset");
      for (int d = 0; d < NDUT; d++) begin
         checkOutput($sformatf("reset dut%0d out_index", d), 32'(out_index[d]), 32'd0);
         checkOutput($sformatf("reset dut%0d out_data", d), 32'(out_data[d]), 32'd0);
         checkOutput($sformatf("reset dut%0d out_last", d), 32'(out_last[d]), 32'd0);
      end

      $display("[TB] fixed window, 16 strobes, ready high");
      applyStimulus(16, 1'b0, 6, 34);
      waitCycles(60);
      checkStatus("fixed");

      $display("[TB] random window, ready 1,0,0 pattern on HOP=16");
      shift_window = 1'b1;
      ready_mode[0] = 2;
      ready_mode[1] = 1;
      applyStimulus(16, 1'b0, 6, 34);
      waitCycles(80);
      checkStatus("pattern");

      $display("[TB] HOP=4 stalled past several hops");
      ready_mode[0] = 1;
      ready_mode[1] = 0;
      ready_force[1] = 1'b0;
      applyStimulus(12, 1'b0, 6, 34);
      checkOutput("stall dut1 overrun", 32'(overrun[1]), 32'(exp_overrun[1]));
      checkOutput("stall dut1 out_valid", 32'(out_valid[1]), 32'd1);
      checkOutput("stall dut1 held index", 32'(out_index[1]), 32'(16 - exp_q[1].size()));
      checkOutput("stall dut1 held data", 32'(out_data[1]), 32'(exp_q[1][0].data));
      ready_force[1] = 1'b1;
      waitCycles(60);
      checkStatus("stall released");
      overrun_clr[1] = 1'b1;
      exp_overrun[1] = 1'b0;
      waitCycles(1);
      overrun_clr[1] = 1'b0;
      waitCycles(1);
      checkOutput("clr dut1 overrun", 32'(overrun[1]), 32'(exp_overrun[1]));

      $display("[TB] overrun clear coincident with a drop");
      ready_force[1] = 1'b0;
      applyStimulus(7, 1'b0, 6, 34);
      applyStimulus(1, 1'b1, 6, 34);
      checkOutput("clr+drop dut1 overrun", 32'(overrun[1]), 32'(exp_overrun[1]));
      ready_force[1] = 1'b1;
      waitCycles(80);
      checkStatus("clr+drop");

      $display("[TB] reset in the middle of a HOP=16 frame");
      ready_mode[0] = 0;
      ready_force[0] = 1'b1;
      applyStimulus(16 - (ticks % 16), 1'b0, 6, 34);
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         waitCycles(1);
         if (out_valid[0] === 1'b1 && out_index[0] === 4'd7) begin
            found = 1'b1;
         end
      end
      checkOutput("mid-stream index 7 reached", 32'(found), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checkOutput($sformatf("async reset dut%0d out_valid", d), 32'(out_valid[d]), 32'd0);
         checkOutput($sformatf("async reset dut%0d busy", d), 32'(busy[d]), 32'd0);
         exp_q[d].delete();
         exp_frames[d] = 0;
         exp_overrun[d] = 1'b0;
      end
      ticks = 0;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(2);
      checkStatus("post reset");
      applyStimulus(15, 1'b0, 6, 34);
      waitCycles(40);
      checkOutput("post reset dut0 no frame yet", 32'(out_valid[0]), 32'd0);
      applyStimulus(1, 1'b0, 6, 34);
      waitCycles(60);
      checkStatus("post reset frame");

      $display("[TB] long random run, HOP=1 frame_count wrap");
      ready_mode[0] = 1;
      ready_mode[1] = 1;
      ready_mode[2] = 0;
      ready_force[2] = 1'b1;
      applyStimulus(240, 1'b0, 6, 34);
      waitCycles(80);
      checkStatus("wrap");
      checkOutput("wrap dut2 frame_count", 32'(frame_count[2]), 32'd0);

      $display("[TB] long strobe levels");
      applyStimulus(3, 1'b0, 120, 120);
      waitCycles(80);
      checkStatus("long level");

      for (int d = 0; d < NDUT; d++) begin
         checkOutput($sformatf("dut%0d beats outstanding", d), 32'(exp_q[d].size()), 32'd0);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sample_frame_reader.md
Name: sample_frame_reader

Overview:
- Consumer end of the microphone sample window.
- Watches the sampling strobe and snapshots the 16-tap, 18-bit sample window (s0 = newest, s15 = oldest) once every HOP new samples.
- Streams the frame out serially, oldest first, over a valid/ready handshake to the downstream FFT/visualiser datapath.
- Runs entirely in the clk_25 domain; clk_sampling is treated as an asynchronous strobe input.

Parameters:
- WIDTH, 18, sample width of each window tap and of out_data.
- HOP, 16, number of new samples between frames; legal range 1..16.

Ports:
- clk_25  input  1  25 MHz system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clk_sampling  input  1  sampling clock from the mic sampler; the window shifts on its rising edge.
- s0 .. s15  input  WIDTH each  sample window; s0 is newest, s15 is oldest; stable between clk_sampling rising edges.
- out_data  output  WIDTH  current sample of the frame being streamed.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_index  output  4  position in frame; 0 = oldest (s15), 15 = newest (s0).
- out_last  output  1  high with out_index == 15.
- busy  output  1  high in CAPTURE or STREAM.
- overrun  output  1  sticky flag: a frame was due while busy and was dropped.
- overrun_clr  input  1  synchronous clear of overrun.
- frame_count  output  8  count of fully transferred frames; wraps 255 -> 0.

Behaviour:
- Reset (async, immediate):
  - out_valid, out_last, busy, overrun = 0.
  - out_data, out_index, frame_count, hop counter, snapshot buffer = 0.
  - Synchroniser flops = 0; state = IDLE.
  - Reset asserted mid-stream aborts the frame; out_valid drops without waiting for a clock.
- Strobe detect:
  - 2-flop synchroniser on clk_sampling, plus a third flop for edge detect.
  - tick = sync2 && !sync3: a one-cycle pulse, 2-3 clk_25 cycles after the clk_sampling rising edge.
  - s0..s15 are sampled only on tick cycles, after they have settled; no other CDC on the window is required.
- Hop counter:
  - Counts ticks 0..HOP-1 and wraps.
  - frame_due pulses on the tick where the counter equals HOP-1.
  - The first frame is due on the HOP-th tick after reset.
- FSM IDLE:
  - out_valid = 0.
  - On frame_due: copy s0..s15 into the 16-entry buffer in that same cycle, then go to CAPTURE.
- FSM CAPTURE (1 cycle):
  - busy = 1.
  - Load out_index = 0 and out_data = buffer[oldest] (s15 copy).
  - Go to STREAM with out_valid = 1 from the next cycle, i.e. out_valid rises 2 cycles after frame_due.
- FSM STREAM:
  - out_valid = 1.
  - While out_ready = 0: out_data, out_index, out_last hold stable.
  - On a transfer with out_index < 15: out_index increments and out_data shows the next-newer sample on the next cycle.
  - Back-to-back transfers run at one per cycle.
  - On a transfer with out_last = 1: frame_count increments, state goes to IDLE, and out_valid and busy are 0 on the next cycle.
- Overrun:
  - frame_due arriving in CAPTURE or STREAM (including the final transfer cycle) drops that frame and sets overrun.
  - The buffer and the current stream are unaffected.
  - The hop counter keeps counting regardless of state.
  - overrun_clr clears overrun; if a set and a clear occur in the same cycle, set wins.
- Width/arith rules:
  - Samples pass through unmodified; no truncation or sign handling.
  - frame_count and the hop counter wrap silently.
  - HOP = 1 makes every tick a frame_due.
- out_ready is ignored when out_valid = 0.

Test Plan:
- Reset, HOP=16; drive s_k = 0x100 + k and generate 16 clk_sampling edges with out_ready = 1 -> exactly one frame; out_data sequence 0x10F, 0x10E, ..., 0x100; out_index 0..15; out_last only on the 16th beat; frame_count = 1; overrun = 0.
- Same frame with out_ready toggling 1,0,0,1,... -> data and index held during ready = 0; all 16 values delivered in order with none duplicated or skipped.
- HOP=4, out_ready held 0 for longer than 4 sample periods -> overrun = 1, first frame still intact when ready rises; overrun_clr pulse -> overrun = 0; clr coincident with a new drop -> overrun stays 1.
- Assert reset while out_index = 7 in STREAM -> out_valid = 0 immediately; after release, no output until HOP new ticks; frame_count = 0.
- HOP=1, out_ready = 1, sampling period of 40 clk_25 cycles -> a frame every sample, no overrun; 256 frames -> frame_count wraps to 0.
- clk_sampling held high for many cycles, then low -> exactly one tick per rising edge; none on the falling edge or on the level.
